// File: rtl/datapath_pkg.sv
// Shared encodings for param_datapath: ALU ops, write-back select, shifter ops,
// multiplier FSM states and status-flag bit positions.
package datapath_pkg;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluNot = 3'b011,
        AluMul = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        VselC     = 2'b00,
        VselPc    = 2'b01,
        VselImm8  = 2'b10,
        VselMdata = 2'b11
    } vsel_e;

    typedef enum logic [1:0] {
        ShPass       = 2'b00,
        ShLeft       = 2'b01,
        ShRightLog   = 2'b10,
        ShRightArith = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } mul_state_e;

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagV = 2;

    function automatic logic [2:0] make_flags(input logic v, input logic n, input logic z);
        logic [2:0] f;
        f        = '0;
        f[FlagV] = v;
        f[FlagN] = n;
        f[FlagZ] = z;
        return f;
    endfunction

endpackage

// File: rtl/param_datapath_if.sv
// Control/data bundle of param_datapath; master drives controls, slave is the datapath.
interface param_datapath_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned PC_W  = 8
);
    localparam int unsigned RW = $clog2(NREGS);

    logic [RW-1:0]    readnum;
    logic [RW-1:0]    writenum;
    logic             write;
    logic [1:0]       vsel;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic             bsel;
    logic [1:0]       shift;
    logic [2:0]       ALUop;
    logic             start;
    logic [WIDTH-1:0] mdata;
    logic [WIDTH-1:0] sximm8;
    logic [WIDTH-1:0] sximm5;
    logic [PC_W-1:0]  PC;
    logic [WIDTH-1:0] datapath_out;
    logic [2:0]       Z_out;
    logic             busy;

    modport master (
        output readnum, writenum, write, vsel, loada, loadb, loadc, loads,
        output asel, bsel, shift, ALUop, start, mdata, sximm8, sximm5, PC,
        input  datapath_out, Z_out, busy
    );

    modport slave (
        input  readnum, writenum, write, vsel, loada, loadb, loadc, loads,
        input  asel, bsel, shift, ALUop, start, mdata, sximm8, sximm5, PC,
        output datapath_out, Z_out, busy
    );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier producing the low WIDTH bits of a*b over WIDTH RUN cycles.
// done pulses combinationally in the last RUN cycle so the result lands on the RUN->DONE edge.
module seq_multiplier
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int unsigned CntW = $clog2(WIDTH);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] step_sum;
    logic             last;

    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last     = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ready   = (state_q == StIdle);
    assign busy    = (state_q == StRun);
    assign done    = busy && last;
    assign product = step_sum;

endmodule

// File: rtl/param_datapath.sv
// Register-file datapath with shifter, ALU, A/B/C/status registers.
// Optional sequential multiplier (ALUop 100) is built in when PARAM_DATAPATH_MUL_EN is defined.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned PC_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    param_datapath_if.slave dp
);
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       status_q;

    logic [WIDTH-1:0] rd_data, wb_data, sh_out, ain, bin, alu_res;
    logic             alu_ovf;
    logic [2:0]       alu_flags;

    logic             c_en, s_en;
    logic [WIDTH-1:0] c_nxt;
    logic [2:0]       s_nxt;

    assign rd_data = regs_q[dp.readnum];

    always_comb begin
        case (dp.vsel)
            VselC:    wb_data = c_q;
            VselPc:   wb_data = WIDTH'(dp.PC);
            VselImm8: wb_data = dp.sximm8;
            default:  wb_data = dp.mdata;
        endcase
    end

    always_comb begin
        case (dp.shift)
            ShPass:     sh_out = b_q;
            ShLeft:     sh_out = b_q << 1;
            ShRightLog: sh_out = b_q >> 1;
            default:    sh_out = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
    end

    assign ain = dp.asel ? '0 : a_q;
    assign bin = dp.bsel ? dp.sximm5 : sh_out;

    // MUL (and undefined codes) yield 0 here; the product comes only from the sequencer.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (dp.ALUop)
            AluAdd: begin
                alu_res = ain + bin;
                alu_ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            AluSub: begin
                alu_res = ain - bin;
                alu_ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            AluAnd:  alu_res = ain & bin;
            AluNot:  alu_res = ~bin;
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = make_flags(alu_ovf, alu_res[WIDTH-1], alu_res == '0);

`ifdef PARAM_DATAPATH_MUL_EN
    logic             mul_start, mul_ready, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             mul_lc_q, mul_ls_q;

    assign mul_start = dp.start && (dp.ALUop == AluMul);

    seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (ain),
        .b      (bin),
        .ready  (mul_ready),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_lc_q <= 1'b0;
            mul_ls_q <= 1'b0;
        end else if (mul_start && mul_ready) begin
            mul_lc_q <= dp.loadc;
            mul_ls_q <= dp.loads;
        end
    end

    // While the multiplier runs, C/status belong to it; MUL itself never loads single-cycle.
    always_comb begin
        c_en  = 1'b0;
        s_en  = 1'b0;
        c_nxt = alu_res;
        s_nxt = alu_flags;
        if (mul_done) begin
            c_en  = mul_lc_q;
            s_en  = mul_ls_q;
            c_nxt = mul_prod;
            s_nxt = make_flags(1'b0, mul_prod[WIDTH-1], mul_prod == '0);
        end else if (!mul_busy && (dp.ALUop != AluMul)) begin
            c_en = dp.loadc;
            s_en = dp.loads;
        end
    end

    assign dp.busy = mul_busy;
`else
    logic unused_start;

    assign unused_start = dp.start;
    assign c_en         = dp.loadc;
    assign s_en         = dp.loads;
    assign c_nxt        = alu_res;
    assign s_nxt        = alu_flags;
    assign dp.busy      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (dp.write) begin
            regs_q[dp.writenum] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            if (dp.loada) a_q <= rd_data;
            if (dp.loadb) b_q <= rd_data;
            if (c_en) c_q <= c_nxt;
            if (s_en) status_q <= s_nxt;
        end
    end

    assign dp.datapath_out = c_q;
    assign dp.Z_out        = status_q;

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath (WIDTH=16, NREGS=8): directed cases plus random stimulus
// against an arithmetic reference model; honours PARAM_DATAPATH_MUL_EN.
module tb_param_datapath;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int PW = 8;
`ifdef PARAM_DATAPATH_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_datapath_if #(.WIDTH(W), .NREGS(N), .PC_W(PW)) dif ();

    param_datapath #(.WIDTH(W), .NREGS(N), .PC_W(PW)) dut (
        .clk  (clk),
        .reset(reset),
        .dp   (dif)
    );

    typedef struct {
        int unsigned due;
        logic [15:0] c;
        logic [2:0]  z;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model state
    logic [15:0] m_regs[N];
    logic [15:0] m_a, m_b, m_c, m_prod;
    logic [2:0]  m_z;
    int          m_rem;
    bit          m_cool, m_lc, m_ls;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic set_idle();
        dif.readnum = '0; dif.writenum = '0; dif.write = 1'b0; dif.vsel = 2'd0;
        dif.loada = 1'b0; dif.loadb = 1'b0; dif.loadc = 1'b0; dif.loads = 1'b0;
        dif.asel = 1'b0; dif.bsel = 1'b0; dif.shift = 2'd0; dif.ALUop = 3'd0;
        dif.start = 1'b0; dif.mdata = '0; dif.sximm8 = '0; dif.sximm5 = '0; dif.PC = '0;
    endtask

    task automatic model_edge();
        logic [15:0] rd, wd, sh, ain, bin, res;
        logic [31:0] p;
        int          sa, sb, sr;
        bit          v, was_busy, is_mul;
        if (reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_a = '0; m_b = '0; m_c = '0; m_z = '0;
            m_rem = 0; m_cool = 0;
            return;
        end
        rd = m_regs[dif.readnum];
        case (dif.vsel)
            2'd0: wd = m_c;
            2'd1: wd = {8'h00, dif.PC};
            2'd2: wd = dif.sximm8;
            default: wd = dif.mdata;
        endcase
        case (dif.shift)
            2'd0: sh = m_b;
            2'd1: sh = (m_b * 2) & 16'hFFFF;
            2'd2: sh = m_b / 2;
            default: sh = (m_b / 2) | (m_b & 16'h8000);
        endcase
        ain = dif.asel ? 16'h0 : m_a;
        bin = dif.bsel ? dif.sximm5 : sh;
        sa  = int'($signed(ain));
        sb  = int'($signed(bin));
        v   = 0;
        case (dif.ALUop)
            3'd0: begin sr = sa + sb; res = sr[15:0]; v = (sr > 32767) || (sr < -32768); end
            3'd1: begin sr = sa - sb; res = sr[15:0]; v = (sr > 32767) || (sr < -32768); end
            3'd2: res = ain & bin;
            3'd3: res = ~bin;
            default: res = 16'h0;
        endcase
        was_busy = (m_rem > 0);
        is_mul   = MulEn && (dif.ALUop == 3'd4);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_lc) m_c = m_prod;
                if (m_ls) m_z = {1'b0, m_prod[15], m_prod == 16'h0};
                m_cool = 1;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (is_mul && dif.start) begin
            p      = ain * bin;
            m_prod = p[15:0];
            m_lc   = dif.loadc;
            m_ls   = dif.loads;
            m_rem  = W;
        end
        if (!was_busy && !is_mul) begin
            if (dif.loadc) m_c = res;
            if (dif.loads) m_z = {v, res[15], res == 16'h0};
        end
        if (dif.write) m_regs[dif.writenum] = wd;
        if (dif.loada) m_a = rd;
        if (dif.loadb) m_b = rd;
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        e.due  = edge_cnt;
        e.c    = m_c;
        e.z    = m_z;
        e.busy = (m_rem > 0);
        e.tag  = tag;
        exp_q.push_back(e);
        set_idle();
    endtask

    task automatic wr(input int idx, input logic [15:0] val);
        dif.vsel = 2'd2; dif.sximm8 = val; dif.writenum = 3'(idx); dif.write = 1'b1;
        step("write");
    endtask

    task automatic lda(input int idx);
        dif.readnum = 3'(idx); dif.loada = 1'b1;
        step("loada");
    endtask

    task automatic ldb(input int idx);
        dif.readnum = 3'(idx); dif.loadb = 1'b1;
        step("loadb");
    endtask

    task automatic alu(input logic [2:0] op, input logic [1:0] sh, input bit as, input bit bs,
                       input bit lc, input bit ls, input string tag);
        dif.ALUop = op; dif.shift = sh; dif.asel = as; dif.bsel = bs;
        dif.loadc = lc; dif.loads = ls;
        step(tag);
    endtask

    // Copies A into C (B operand forced to sximm5 = 0).
    task automatic show_a(input string tag);
        alu(3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, tag);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.due != edge_cnt) check({e.tag, "_stale"}, 16'(edge_cnt), 16'(e.due));
                check({e.tag, "_C"}, dif.datapath_out, e.c);
                check({e.tag, "_Z"}, 16'(dif.Z_out), 16'(e.z));
                check({e.tag, "_busy"}, 16'(dif.busy), 16'(e.busy));
            end
        end
    end

    initial begin
        set_idle();
        reset = 1'b1;
        step("reset0");
        step("reset1");
        reset = 1'b0;

        // Same-cycle write/read returns old value, next read sees new value
        dif.vsel = 2'd2; dif.sximm8 = 16'h00AA; dif.writenum = 3'd2; dif.write = 1'b1;
        dif.readnum = 3'd2; dif.loada = 1'b1;
        step("rw_same");
        show_a("a_old");
        lda(2);
        show_a("a_new");

        // ADD 7 + 5
        wr(3, 16'h0007);
        wr(5, 16'h0005);
        lda(3);
        ldb(5);
        alu(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "add_7_5");

        // Signed overflow
        wr(1, 16'h7FFF);
        wr(2, 16'h0001);
        lda(1);
        ldb(2);
        alu(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "add_ovf");
        alu(3'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "sub");
        alu(3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "and");
        alu(3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "not");

        // Shifter with asel zeroing A
        wr(4, 16'h8002);
        ldb(4);
        alu(3'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, "asr");
        alu(3'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, "lsr");
        alu(3'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, "lsl");

        // Write-back sources: PC, mdata, C
        dif.vsel = 2'd1; dif.PC = 8'hA5; dif.writenum = 3'd6; dif.write = 1'b1;
        step("wb_pc");
        dif.vsel = 2'd3; dif.mdata = 16'hBEEF; dif.writenum = 3'd7; dif.write = 1'b1;
        step("wb_mdata");
        dif.vsel = 2'd0; dif.writenum = 3'd0; dif.write = 1'b1;
        step("wb_c");
        for (int r = 6; r < 8; r++) begin
            lda(r);
            show_a("wb_read");
        end
        lda(0);
        show_a("wb_read_c");

        // MUL 0x12 * 3 with a mid-op loadc pulse
        wr(3, 16'h0012);
        wr(5, 16'h0003);
        lda(3);
        ldb(5);
        dif.start = 1'b1;
        alu(3'd4, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mul_start");
        for (int k = 1; k <= W + 2; k++) begin
            if (k == 8) alu(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mul_midload");
            else step("mul_run");
        end

        // Reset aborts MUL; all registers then read 0
        dif.start = 1'b1;
        alu(3'd4, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mul2_start");
        for (int k = 0; k < 3; k++) step("mul2_run");
        reset = 1'b1;
        step("mul2_reset");
        reset = 1'b0;
        for (int r = 0; r < N; r++) begin
            dif.readnum = 3'(r); dif.loada = 1'b1; dif.loadb = 1'b1;
            step("post_rst_load");
            alu(3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst_read");
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 79) == 0);
            dif.readnum  = 3'($urandom_range(0, 7));
            dif.writenum = 3'($urandom_range(0, 7));
            dif.write    = $urandom_range(0, 1) == 1;
            dif.vsel     = 2'($urandom_range(0, 3));
            dif.loada    = $urandom_range(0, 2) == 0;
            dif.loadb    = $urandom_range(0, 2) == 0;
            dif.loadc    = $urandom_range(0, 1) == 1;
            dif.loads    = $urandom_range(0, 1) == 1;
            dif.asel     = $urandom_range(0, 3) == 0;
            dif.bsel     = $urandom_range(0, 3) == 0;
            dif.shift    = 2'($urandom_range(0, 3));
            dif.ALUop    = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            dif.start    = $urandom_range(0, 5) == 0;
            dif.mdata    = 16'($urandom);
            dif.sximm8   = 16'($urandom);
            dif.sximm5   = 16'($urandom);
            dif.PC       = 8'($urandom);
            step("rand");
        end
        reset = 1'b0;
        for (int k = 0; k < W + 3; k++) step("drain");

        @(negedge clk);
        #1;
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
